input_conditioner: RTL and testbench

// Upstream front end for the 8-bit counter: conditions raw pad inputs (ui_in[3:0]:

---
 rtl/input_conditioner.sv | 107 ++++++++++
 tb/tb_input_conditioner.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : input_conditioner
// Description : Pad-input front end for the counter core. Each channel gets a
//               two-flop synchroniser, a counter-based debounce filter and
//               registered single-cycle rise/fall strobes on the filtered level.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk         in   1     system clock
//   rst_n       in   1     asynchronous active-low reset
//   ena         in   1     enable; low freezes the filter and silences strobes
//   raw_in      in   N_CH  unsynchronised pad inputs
//   level_out   out  N_CH  debounced level per channel
//   rise_pulse  out  N_CH  one-cycle strobe when level_out goes 0->1
//   fall_pulse  out  N_CH  one-cycle strobe when level_out goes 1->0
// ============================================================================
module input_conditioner #(
  parameter int N_CH            = 4,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int CNT_W           = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ena,
  input  logic [N_CH-1:0] raw_in,
  output logic [N_CH-1:0] level_out,
  output logic [N_CH-1:0] rise_pulse,
  output logic [N_CH-1:0] fall_pulse
);

  // Count value at which a differing synced input is accepted. Acceptance
  // clears the counter, so it never needs to go beyond this value.
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);

  // --------------------------------------------------------------------------
  // Two-flop synchroniser, free-running regardless of ena
  // --------------------------------------------------------------------------
  logic [N_CH-1:0] s1_q;
  logic [N_CH-1:0] s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= raw_in;
      s2_q <= s1_q;
    end
  end

  // --------------------------------------------------------------------------
  // Per-channel debounce filter and strobe generation
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_q;
    logic             level_d;
    logic             rise_q;
    logic             rise_d;
    logic             fall_q;
    logic             fall_d;

    always_comb begin
      cnt_d   = cnt_q;
      level_d = level_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      if (ena) begin
        if (s2_q[i] == level_q) begin
          // Input agrees with the accepted level: any partial
          // qualification was a glitch and is discarded.
          cnt_d = '0;
        end else if (cnt_q == c_cnt_last) begin
          // Held long enough: accept and strobe in the same cycle.
          level_d = s2_q[i];
          cnt_d   = '0;
          rise_d  = s2_q[i];
          fall_d  = ~s2_q[i];
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q   <= '0;
        level_q <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        cnt_q   <= cnt_d;
        level_q <= level_d;
        rise_q  <= rise_d;
        fall_q  <= fall_d;
      end
    end

    assign level_out[i]  = level_q;
    assign rise_pulse[i] = rise_q;
    assign fall_pulse[i] = fall_q;
  end : g_ch

endmodule : input_conditioner
`default_nettype wire

// File: tb/tb_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_input_conditioner
// Description : Self-checking bench for input_conditioner with a short
//               debounce window. Directed scenarios followed by random pad
//               activity, all compared each cycle against a reference model
//               that tracks how long each channel's synchronised input has
//               disagreed with its accepted level.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_input_conditioner;

  localparam int N_CH = 4;
  localparam int DC   = 4;
  localparam int CW   = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            ena;
  logic [N_CH-1:0] raw_in;
  logic [N_CH-1:0] level_out;
  logic [N_CH-1:0] rise_pulse;
  logic [N_CH-1:0] fall_pulse;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  // Reference model state: raw value two edges back, accepted level, strobes,
  // and the number of consecutive enabled edges the synced input disagreed.
  logic [N_CH-1:0] m_s1, m_s2, m_lvl, m_rise, m_fall;
  int              m_streak [N_CH];

  input_conditioner #(
    .N_CH            (N_CH),
    .DEBOUNCE_CYCLES (DC),
    .CNT_W           (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .raw_in     (raw_in),
    .level_out  (level_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_s1   = '0;
    m_s2   = '0;
    m_lvl  = '0;
    m_rise = '0;
    m_fall = '0;
    for (int c = 0; c < N_CH; c++) m_streak[c] = 0;
  endtask

  // Model behaviour at one rising edge, using the inputs present before it.
  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int c = 0; c < N_CH; c++) begin
      m_rise[c] = 1'b0;
      m_fall[c] = 1'b0;
      if (ena) begin
        if (m_s2[c] != m_lvl[c]) begin
          m_streak[c] = m_streak[c] + 1;
          if (m_streak[c] == DC) begin
            m_lvl[c]    = m_s2[c];
            m_streak[c] = 0;
            if (m_lvl[c]) m_rise[c] = 1'b1;
            else          m_fall[c] = 1'b1;
          end
        end else begin
          m_streak[c] = 0;
        end
      end
    end
    m_s2 = m_s1;
    m_s1 = raw_in;
  endtask

  task automatic check(input string tag, input logic [N_CH-1:0] obs,
                       input logic [N_CH-1:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One clock: model follows the edge, outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("model_level", level_out,  m_lvl);
    check("model_rise",  rise_pulse, m_rise);
    check("model_fall",  fall_pulse, m_fall);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  logic [N_CH-1:0] acc;

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b1;
    raw_in = '0;
    model_reset();
    #1;
    check("reset_level", level_out,  4'b0000);
    check("reset_rise",  rise_pulse, 4'b0000);
    check("reset_fall",  fall_pulse, 4'b0000);
    ticks(2);
    rst_n = 1'b1;
    ticks(4);

    // 1: clean press on channel 0
    raw_in = 4'b0001;
    ticks(5);
    check("t1_level_early", level_out, 4'b0000);
    tick();
    check("t1_level",  level_out,  4'b0001);
    check("t1_rise",   rise_pulse, 4'b0001);
    check("t1_fall",   fall_pulse, 4'b0000);
    tick();
    check("t1_rise_once", rise_pulse, 4'b0000);
    ticks(13);

    // 2: bouncing press on channel 1
    acc = '0;
    raw_in[1] = 1'b1; tick(); acc |= rise_pulse;
    raw_in[1] = 1'b0; tick(); acc |= rise_pulse;
    raw_in[1] = 1'b1; tick(); acc |= rise_pulse;
    raw_in[1] = 1'b0; tick(); acc |= rise_pulse;
    raw_in[1] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      acc |= rise_pulse;
    end
    check("t2_no_bounce_rise", acc, 4'b0000);
    tick();
    check("t2_rise",  rise_pulse, 4'b0010);
    check("t2_level", level_out,  4'b0011);
    ticks(3);

    // 3: short low glitch on channel 0, then real release
    acc = '0;
    raw_in[0] = 1'b0; ticks(3);
    raw_in[0] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      acc |= fall_pulse;
    end
    check("t3_glitch_fall",  acc,       4'b0000);
    check("t3_glitch_level", level_out, 4'b0011);
    raw_in[0] = 1'b0;
    ticks(5);
    check("t3_level_early", level_out, 4'b0011);
    tick();
    check("t3_level", level_out,  4'b0010);
    check("t3_fall",  fall_pulse, 4'b0001);
    tick();
    check("t3_fall_once", fall_pulse, 4'b0000);

    // 4: all channels pressed on the same edge
    raw_in = 4'b0000;
    ticks(10);
    raw_in = 4'b1111;
    ticks(5);
    check("t4_rise_early", rise_pulse, 4'b0000);
    tick();
    check("t4_rise_all", rise_pulse, 4'b1111);
    tick();
    check("t4_rise_once", rise_pulse, 4'b0000);
    ticks(3);

    // 5: disable partway through qualification
    raw_in = 4'b0000;
    ticks(4);
    ena = 1'b0;
    acc = '0;
    for (int k = 0; k < 10; k++) begin
      tick();
      acc |= fall_pulse;
    end
    check("t5_hold_level", level_out, 4'b1111);
    check("t5_hold_fall",  acc,       4'b0000);
    ena = 1'b1;
    tick();
    check("t5_level_mid", level_out, 4'b1111);
    tick();
    check("t5_level", level_out,  4'b0000);
    check("t5_fall",  fall_pulse, 4'b1111);
    ticks(3);

    // 6: asynchronous reset while qualifying
    raw_in = 4'b1111;
    ticks(6);
    check("t6_pre_level", level_out, 4'b1111);
    raw_in = 4'b0011;
    ticks(3);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("t6_async_level", level_out,  4'b0000);
    check("t6_async_rise",  rise_pulse, 4'b0000);
    check("t6_async_fall",  fall_pulse, 4'b0000);
    ticks(2);
    #2;
    rst_n = 1'b1;
    acc = '0;
    for (int k = 0; k < 5; k++) begin
      tick();
      acc |= rise_pulse;
    end
    check("t6_no_early_rise", acc, 4'b0000);
    tick();
    check("t6_rise",  rise_pulse, 4'b0011);
    check("t6_level", level_out,  4'b0011);
    tick();
    check("t6_rise_once", rise_pulse, 4'b0000);

    // Random pad activity with occasional disables
    for (int k = 0; k < 600; k++) begin
      for (int c = 0; c < N_CH; c++)
        if ($urandom_range(0, 7) == 0) raw_in[c] = ~raw_in[c];
      ena = ($urandom_range(0, 9) != 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_input_conditioner
`default_nettype wire
